uart_load_ctrl: RTL
===================

Name: uart_load_ctrl

Overview:
- Sequencer for the UART byte-in interface. It pulses that interface's read-enable once per byte and collects a length-prefixed frame from the host.
- Payload bytes are packed into WORD_BYTES-wide words and written to an on-chip buffer (weights/image) at incrementing addresses.
- Sits between the UART receive path and SoPU buffer memory. Reports done, timeout and byte count to the top-level control FSM.

Parameters:
- WORD_BYTES, 4, bytes per memory word (1..8); mem_wdata width = 8*WORD_BYTES.
- ADDR_W, 10, memory address width.
- BASE_ADDR, 0, first write address of each frame.
- TIMEOUT_CYCLES, 1000000, max clk cycles waiting for any single byte; range 1..2^24-1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin frame load; sampled only in IDLE.
- rd_en  out  1  one-cycle pulse requesting one byte from the byte-in interface.
- byte_vld  in  1  one-cycle strobe: byte_in holds a received byte.
- byte_in  in  8  received byte.
- mem_we  out  1  one-cycle write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8*WORD_BYTES  packed word; first byte in bits [7:0].
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse at frame end (success or error).
- err_timeout  out  1  sticky; set on byte timeout, cleared on next accepted start.
- byte_count  out  16  payload bytes received in current/last frame.
- err_checksum  out  1  see Optional Feature.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; all outputs 0; mem_addr=BASE_ADDR; internal length, byte lane and timer = 0. Reset mid-frame aborts immediately with no further mem_we. Partial word data is discarded.
- States: IDLE, HDR_REQ, HDR_WAIT, DATA_REQ, DATA_WAIT, FLUSH, CK_REQ, CK_WAIT, DONE.
- IDLE:
  - start=1 -> HDR_REQ.
  - Clear byte_count, err flags, hdr index, lane; mem_addr<=BASE_ADDR.
  - start while not IDLE is ignored.
- HDR_REQ:
  - rd_en=1 for this one cycle; timer<=0; -> HDR_WAIT.
- HDR_WAIT:
  - byte_vld=1: store byte. First header byte = length[15:8], second = length[7:0] (big-endian).
  - After byte 1 -> HDR_REQ.
  - After byte 2: length==0 -> DONE (no writes); else -> DATA_REQ.
- DATA_REQ:
  - rd_en pulse; timer<=0; -> DATA_WAIT.
- DATA_WAIT:
  - byte_vld=1: byte goes to lane (byte_count mod WORD_BYTES) of the word register; byte_count+1.
  - If lane was WORD_BYTES-1: mem_we=1 next cycle with the full word and current mem_addr, then mem_addr+1. Address wraps modulo 2^ADDR_W with no error.
  - If byte_count reaches length -> FLUSH; else -> DATA_REQ.
- FLUSH:
  - If a partial word is pending, issue one mem_we with unused upper lanes = 0, then mem_addr+1.
  - -> CK_REQ if checksum compiled in, else DONE.
- Timeout:
  - In any *_WAIT state, timer increments each cycle without byte_vld.
  - timer==TIMEOUT_CYCLES-1 with no byte_vld: err_timeout<=1 -> DONE. No flush of partial data.
  - byte_vld on that same cycle wins; no timeout is taken.
- DONE: done=1 for one cycle, busy<=0 -> IDLE.
- byte_vld outside *_WAIT states is ignored and counted nowhere.
- Latency: rd_en to byte_vld is set by the byte-in interface (≥2 cycles). The controller adds 1 cycle between byte_vld and the next rd_en.
- mem_wdata is valid only while mem_we=1; otherwise holds its last value.

Optional Feature:
- Macro: UART_LOAD_CHECKSUM_EN.
- Defined:
  - After FLUSH, one trailer byte is requested (CK_REQ/CK_WAIT, same rd_en/timeout rules).
  - Expected value = 8-bit wrapping sum of all payload bytes; header bytes are excluded.
  - Mismatch sets sticky err_checksum, cleared on next accepted start. Then -> DONE.
  - A length==0 frame still reads the checksum byte; expected value = 0x00.
- Undefined: no CK states, err_checksum tied 0, no trailer byte read.

Test Plan:
- Reset mid-DATA_WAIT, then release -> state IDLE, all outputs 0, no mem_we after reset asserted.
- start; bytes 0x00,0x08, then 0x01..0x08 (WORD_BYTES=4, BASE_ADDR=0) -> writes 0x04030201@0, 0x08070605@1; byte_count=8; done pulse; exactly 10 rd_en pulses.
- Header 0x00,0x05, payload 0xAA..0xAE -> writes 0xADACABAA@0, 0x000000AE@1 (flush zero-pad); done.
- Header 0x00,0x00 -> no mem_we, done one cycle after second header byte, byte_count=0.
- TIMEOUT_CYCLES=16, header 0x00,0x04, 2 payload bytes then silence -> err_timeout=1 exactly 16 cycles after the 3rd-byte rd_en wait begins; done; no mem_we; next start clears err_timeout.
- UART_LOAD_CHECKSUM_EN, ADDR_W=2, BASE_ADDR=3, 8 bytes 0x01..0x08, trailer 0x24 -> addresses 3 then 0 (wrap), err_checksum=0. Same frame with trailer 0x25 -> err_checksum=1.

Source files
------------

// File: rtl/uart_load_ctrl.sv
// uart_load_ctrl: sequences the UART byte-in interface to pull a length-prefixed
// frame (16-bit big-endian length, then payload) and packs the payload into
// WORD_BYTES-wide words written to buffer memory at incrementing addresses.
// Optional feature macro: UART_LOAD_CHECKSUM_EN. When defined, one trailer byte
// holding the 8-bit wrapping sum of the payload is read and verified after the
// payload; when undefined, no trailer is read and err_checksum is tied low.
module uart_load_ctrl #(
    parameter int WORD_BYTES     = 4,
    parameter int ADDR_W         = 10,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    rd_en,
    input  logic                    byte_vld,
    input  logic [7:0]              byte_in,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err_timeout,
    output logic [15:0]             byte_count,
    output logic                    err_checksum
);

    localparam int                WORD_W    = 8 * WORD_BYTES;
    localparam int                LANE_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);
    localparam logic [23:0]       TMO_LAST  = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_REQ,
        S_HDR_WAIT,
        S_DATA_REQ,
        S_DATA_WAIT,
        S_FLUSH,
`ifdef UART_LOAD_CHECKSUM_EN
        S_CK_REQ,
        S_CK_WAIT,
`endif
        S_DONE
    } state_t;

    // Where a frame goes once the payload is finished (or is empty).
`ifdef UART_LOAD_CHECKSUM_EN
    localparam state_t S_AFTER_PAYLOAD = S_CK_REQ;
`else
    localparam state_t S_AFTER_PAYLOAD = S_DONE;
`endif

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_length;
    logic [15:0]         r_byte_count;
    logic [LANE_W-1:0]   r_lane;
    logic [23:0]         r_timer;
    logic                r_hdr_idx;
    logic                r_err_timeout;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [WORD_W-1:0]   r_mem_wdata;
    logic [WORD_W-1:0]   r_word;
    logic [WORD_W-1:0]   w_word_ins;
    logic [15:0]         w_len_full;
    logic [15:0]         w_count_inc;
    logic                w_tmo;
    logic                w_last_lane;
`ifdef UART_LOAD_CHECKSUM_EN
    logic [7:0]          r_sum;
    logic                r_err_ck;
`endif

    assign w_len_full  = {r_length[15:8], byte_in};
    assign w_count_inc = r_byte_count + 16'd1;
    assign w_tmo       = (r_timer == TMO_LAST) && !byte_vld;
    assign w_last_lane = (r_lane == LAST_LANE);

    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign err_timeout = r_err_timeout;
    assign byte_count  = r_byte_count;
`ifdef UART_LOAD_CHECKSUM_EN
    assign err_checksum = r_err_ck;
`else
    assign err_checksum = 1'b0;
`endif

    // Insert the incoming byte into its lane; a fresh word starts from zero so
    // a flushed partial word carries zeros in its unused upper lanes.
    always_comb begin
        w_word_ins = (r_lane == '0) ? '0 : r_word;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_word_ins[8*i +: 8] = byte_in;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs (rd_en, done, busy).
    always_comb begin
        w_next = r_state;
        rd_en  = 1'b0;
        done   = 1'b0;
        busy   = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_HDR_REQ;
            end
            S_HDR_REQ: begin
                rd_en  = 1'b1;
                w_next = S_HDR_WAIT;
            end
            S_HDR_WAIT: begin
                if (byte_vld) begin
                    if (!r_hdr_idx)                w_next = S_HDR_REQ;
                    else if (w_len_full == 16'd0)  w_next = S_AFTER_PAYLOAD;
                    else                           w_next = S_DATA_REQ;
                end else if (w_tmo) begin
                    w_next = S_DONE;
                end
            end
            S_DATA_REQ: begin
                rd_en  = 1'b1;
                w_next = S_DATA_WAIT;
            end
            S_DATA_WAIT: begin
                if (byte_vld) begin
                    w_next = (w_count_inc == r_length) ? S_FLUSH : S_DATA_REQ;
                end else if (w_tmo) begin
                    w_next = S_DONE;
                end
            end
            S_FLUSH: begin
                w_next = S_AFTER_PAYLOAD;
            end
`ifdef UART_LOAD_CHECKSUM_EN
            S_CK_REQ: begin
                rd_en  = 1'b1;
                w_next = S_CK_WAIT;
            end
            S_CK_WAIT: begin
                if (byte_vld || w_tmo) w_next = S_DONE;
            end
`endif
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Frame datapath: header capture, byte counting, timer, write issue, flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_length      <= '0;
            r_byte_count  <= '0;
            r_lane        <= '0;
            r_timer       <= '0;
            r_hdr_idx     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= BASE;
            r_mem_wdata   <= '0;
`ifdef UART_LOAD_CHECKSUM_EN
            r_sum         <= '0;
            r_err_ck      <= 1'b0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            // A write presented this cycle advances the address; wraps freely.
            if (r_mem_we) r_mem_addr <= r_mem_addr + ADDR_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_byte_count  <= '0;
                        r_err_timeout <= 1'b0;
                        r_hdr_idx     <= 1'b0;
                        r_lane        <= '0;
                        r_mem_addr    <= BASE;
`ifdef UART_LOAD_CHECKSUM_EN
                        r_sum         <= '0;
                        r_err_ck      <= 1'b0;
`endif
                    end
                end
                S_HDR_REQ, S_DATA_REQ: begin
                    r_timer <= '0;
                end
                S_HDR_WAIT: begin
                    if (byte_vld) begin
                        if (!r_hdr_idx) begin
                            r_length[15:8] <= byte_in;
                            r_hdr_idx      <= 1'b1;
                        end else begin
                            r_length[7:0]  <= byte_in;
                        end
                    end else if (w_tmo) begin
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 24'd1;
                    end
                end
                S_DATA_WAIT: begin
                    if (byte_vld) begin
                        r_byte_count <= w_count_inc;
                        r_lane       <= w_last_lane ? '0 : r_lane + LANE_W'(1);
`ifdef UART_LOAD_CHECKSUM_EN
                        r_sum        <= r_sum + byte_in;
`endif
                        if (w_last_lane) begin
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= w_word_ins;
                        end
                    end else if (w_tmo) begin
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 24'd1;
                    end
                end
                S_FLUSH: begin
                    if (r_lane != '0) begin
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= r_word;
                        r_lane      <= '0;
                    end
                end
`ifdef UART_LOAD_CHECKSUM_EN
                S_CK_REQ: begin
                    r_timer <= '0;
                end
                S_CK_WAIT: begin
                    if (byte_vld) begin
                        if (byte_in != r_sum) r_err_ck <= 1'b1;
                    end else if (w_tmo) begin
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 24'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Word assembly register; partial contents are simply overwritten by the
    // next frame, so it carries no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_DATA_WAIT && byte_vld) begin
            r_word <= w_word_ins;
        end
    end

endmodule
